// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 UART transmitter with optional parity and second stop bit
module uart_tx_byte #(
    parameter int CLK_FREQ   = 24_000_000,
    parameter int BAUD       = 115200,
    parameter int DIV        = CLK_FREQ / BAUD,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk_24m,
    input  logic       rstn,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       txd,
    output logic       idle,
    output logic       tx_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [15:0] DIV_LAST  = 16'(DIV - 1);
    localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic        PAR_SENSE = (PARITY_ODD != 0);

    state_t      r_state;
    logic [15:0] r_baud_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        r_parity;
    logic        w_tc;

    assign w_tc = (r_baud_cnt == DIV_LAST);

    always_ff @(posedge clk_24m or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            txd        <= 1'b1;
            idle       <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (r_state != S_IDLE) begin
                r_baud_cnt <= w_tc ? 16'd0 : r_baud_cnt + 16'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (tx_start) begin
                        r_shift    <= tx_data;
                        r_parity   <= (^tx_data) ^ PAR_SENSE;
                        r_baud_cnt <= '0;
                        r_bit_idx  <= '0;
                        txd        <= 1'b0;
                        idle       <= 1'b1;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    if (w_tc) begin
                        txd     <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_state <= S_DATA;
                    end
                end
                // r_shift[0] always holds the next bit to put on the line
                S_DATA: begin
                    if (w_tc) begin
                        if (r_bit_idx == 3'd7) begin
                            r_bit_idx <= '0;
                            if (PARITY_EN != 0) begin
                                txd     <= r_parity;
                                r_state <= S_PARITY;
                            end else begin
                                txd     <= 1'b1;
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            txd       <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_tc) begin
                        txd     <= 1'b1;
                        r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_tc) begin
                        if (r_bit_idx == STOP_LAST) begin
                            r_bit_idx <= '0;
                            idle      <= 1'b0;
                            tx_done   <= 1'b1;
                            r_state   <= S_IDLE;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end
                default: begin
                    txd     <= 1'b1;
                    idle    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_byte.sv
// tb/tb_uart_tx_byte.sv - directed vector bench for uart_tx_byte (8N1 and 8E2 instances)
module tb_uart_tx_byte;

    localparam int DIV = 208;

    logic       clk_24m = 1'b0;
    logic       rstn;
    logic [7:0] tx_data0, tx_data1;
    logic       tx_start0, tx_start1;
    logic       txd0, idle0, done0;
    logic       txd1, idle1, done1;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt0 = 0;
    int done_cnt1 = 0;
    int exp_done0 = 0;
    int exp_done1 = 0;

    always #5 clk_24m = ~clk_24m;

    uart_tx_byte dut0 (
        .clk_24m(clk_24m), .rstn(rstn), .tx_data(tx_data0), .tx_start(tx_start0),
        .txd(txd0), .idle(idle0), .tx_done(done0)
    );

    uart_tx_byte #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut1 (
        .clk_24m(clk_24m), .rstn(rstn), .tx_data(tx_data1), .tx_start(tx_start1),
        .txd(txd1), .idle(idle1), .tx_done(done1)
    );

    always @(negedge clk_24m) begin
        if (done0) done_cnt0++;
        if (done1) done_cnt1++;
    end

    typedef struct {
        int         sel;
        logic [7:0] data;
        int         nbits;
        logic [11:0] line;
        int         idle_w;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_start(input int sel, input logic s, input logic [7:0] d);
        if (sel == 0) begin tx_start0 = s; tx_data0 = d; end
        else begin tx_start1 = s; tx_data1 = d; end
    endtask

    // Call at a falling edge; the request is sampled at the next rising edge.
    task automatic run_frame(input int sel, input logic [7:0] data, input int nbits,
                             input logic [11:0] line, input int inject_at, input int rst_at,
                             output int bad, output int idle_w, output logic done_ok,
                             output logic [7:0] dec);
        logic t, i, d, e;
        bad = 0; idle_w = 0; done_ok = 1'b0; dec = '0;
        set_start(sel, 1'b1, data);
        @(negedge clk_24m);
        set_start(sel, 1'b0, data);
        for (int k = 0; k < 4000; k++) begin
            if (k == rst_at) begin
                rstn = 1'b0;
                #1;
                check("async reset txd", int'(sel == 0 ? txd0 : txd1), 1);
                check("async reset idle", int'(sel == 0 ? idle0 : idle1), 0);
                break;
            end
            if (k == inject_at) set_start(sel, 1'b1, 8'hFF);
            if (k == inject_at + 1) set_start(sel, 1'b0, 8'hFF);
            t = (sel == 0) ? txd0 : txd1;
            i = (sel == 0) ? idle0 : idle1;
            d = (sel == 0) ? done0 : done1;
            if (!i) begin
                done_ok = d;
                break;
            end
            idle_w++;
            e = (k / DIV < nbits) ? line[k / DIV] : 1'b1;
            if (t != e) bad++;
            if (k % DIV == DIV / 2 && k / DIV >= 1 && k / DIV <= 8) dec[k / DIV - 1] = t;
            @(negedge clk_24m);
        end
    endtask

    initial begin
        vec_t vecs[6];
        int bad, idle_w, quiet_bad, done_before;
        logic done_ok;
        logic [7:0] dec;

        vecs[0] = '{0, 8'h55, 10, 12'b00_1010101010, 2080};
        vecs[1] = '{1, 8'h07, 12, 12'b111000001110, 2496};
        vecs[2] = '{0, 8'h00, 10, 12'b00_1000000000, 2080};
        vecs[3] = '{0, 8'hFF, 10, 12'b00_1111111110, 2080};
        vecs[4] = '{1, 8'h00, 12, 12'b110000000000, 2496};
        vecs[5] = '{1, 8'h80, 12, 12'b111100000000, 2496};

        rstn = 1'b0;
        tx_start0 = 1'b0; tx_start1 = 1'b0; tx_data0 = '0; tx_data1 = '0;
        repeat (3) @(negedge clk_24m);
        check("reset txd0", int'(txd0), 1);
        check("reset idle0", int'(idle0), 0);
        check("reset done0", int'(done0), 0);
        check("reset txd1", int'(txd1), 1);
        check("reset idle1", int'(idle1), 0);
        rstn = 1'b1;

        quiet_bad = 0;
        repeat (1000) begin
            @(negedge clk_24m);
            if (txd0 !== 1'b1 || idle0 !== 1'b0 || done0 !== 1'b0) quiet_bad++;
        end
        check("quiet line", quiet_bad, 0);
        check("quiet done count", done_cnt0, 0);

        for (int v = 0; v < 6; v++) begin
            @(negedge clk_24m);
            run_frame(vecs[v].sel, vecs[v].data, vecs[v].nbits, vecs[v].line, -1, -1,
                      bad, idle_w, done_ok, dec);
            if (vecs[v].sel == 0) exp_done0++; else exp_done1++;
            check($sformatf("vec%0d line bits", v), bad, 0);
            check($sformatf("vec%0d idle width", v), idle_w, vecs[v].idle_w);
            check($sformatf("vec%0d tx_done", v), int'(done_ok), 1);
            check($sformatf("vec%0d decoded", v), int'(dec), int'(vecs[v].data));
            repeat (5) @(negedge clk_24m);
        end

        // start request with a new byte in the middle of a frame
        @(negedge clk_24m);
        run_frame(0, 8'h55, 10, 12'b00_1010101010, 500, -1, bad, idle_w, done_ok, dec);
        exp_done0++;
        check("ignore start line", bad, 0);
        check("ignore start decoded", int'(dec), 8'h55);
        check("ignore start idle", idle_w, 2080);
        quiet_bad = 0;
        repeat (300) begin
            @(negedge clk_24m);
            if (txd0 !== 1'b1 || idle0 !== 1'b0) quiet_bad++;
        end
        check("no second frame", quiet_bad, 0);

        // back-to-back frames, second request in the first idle cycle
        @(negedge clk_24m);
        run_frame(0, 8'hA5, 10, 12'b00_1101001010, -1, -1, bad, idle_w, done_ok, dec);
        exp_done0++;
        check("b2b first decoded", int'(dec), 8'hA5);
        check("b2b first line", bad, 0);
        check("b2b gap txd", int'(txd0), 1);
        check("b2b first done", int'(done_ok), 1);
        run_frame(0, 8'h3C, 10, 12'b00_1001111000, -1, -1, bad, idle_w, done_ok, dec);
        exp_done0++;
        check("b2b second decoded", int'(dec), 8'h3C);
        check("b2b second line", bad, 0);
        check("b2b second idle", idle_w, 2080);

        // reset mid-frame, then a clean frame
        @(negedge clk_24m);
        done_before = done_cnt0;
        run_frame(0, 8'h55, 10, 12'b00_1010101010, -1, 900, bad, idle_w, done_ok, dec);
        repeat (3) @(negedge clk_24m);
        check("reset no done", done_cnt0, done_before);
        check("reset held txd", int'(txd0), 1);
        rstn = 1'b1;
        @(negedge clk_24m);
        run_frame(0, 8'h96, 10, 12'b00_1100101100, -1, -1, bad, idle_w, done_ok, dec);
        exp_done0++;
        check("post reset line", bad, 0);
        check("post reset decoded", int'(dec), 8'h96);
        check("post reset idle", idle_w, 2080);

        repeat (3) @(negedge clk_24m);
        check("total done dut0", done_cnt0, exp_done0);
        check("total done dut1", done_cnt1, exp_done1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
